gol_gen_sequencer: RTL

Single-clock, parametrised generation sequencer for the Game of Life cell array. It replaces the two-phase controller and drives the array's load, evolve and writeout strobes. It tracks cell index, generation count and inter-generation hold time, and resolves win (generation limit reached) and lose (external `lose_sig`) as sticky terminal states. It sits between the user/host controls and the cell-array datapath.

---
 rtl/gol_gen_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/gol_gen_sequencer.sv
// ---------------------------------------------------------------------------
// gol_gen_sequencer
//
// Generation sequencer for the Game of Life cell array. It drives the array's
// load, evolve and writeout strobes. It tracks the position within a pass,
// the number of evolved generations and the idle hold between generations.
// Win (generation limit reached) and lose (external lose_sig) are sticky
// terminal states that only reset leaves.
//
// Ports
//   clka          : clock, all logic on the rising edge
//   reset         : synchronous, active-high reset (forces RESTART)
//   i_load_req    : level, start a load pass from IDLE
//   i_run         : level, continuous evolution enable
//   i_step_req    : level, single evolve pass from IDLE
//   i_pause       : level, blocks entry to EVOLVE from IDLE/HOLD
//   i_lose_sig    : lose condition reported by the array
//   o_state       : current state encoding
//   o_load_en, o_read_en, o_write_en, o_writeout,
//   o_restart, o_win, o_lose, o_busy : registered Moore strobes/flags
//   o_cell_idx    : position within the current LOAD/EVOLVE pass
//   o_gen_count   : generations evolved since the last load/reset
//   o_hold_count  : position within HOLD
// ---------------------------------------------------------------------------
module gol_gen_sequencer #(
  parameter int CELLS       = 16,
  parameter int CNT_W       = 4,
  parameter int GEN_LIMIT   = 50,
  parameter int GEN_W       = 9,
  parameter int HOLD_CYCLES = 5,
  parameter int HOLD_W      = 3
) (
  input  logic              clka,
  input  logic              reset,
  input  logic              i_load_req,
  input  logic              i_run,
  input  logic              i_step_req,
  input  logic              i_pause,
  input  logic              i_lose_sig,
  output logic [2:0]        o_state,
  output logic              o_load_en,
  output logic              o_read_en,
  output logic              o_write_en,
  output logic              o_writeout,
  output logic              o_restart,
  output logic              o_win,
  output logic              o_lose,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_cell_idx,
  output logic [GEN_W-1:0]  o_gen_count,
  output logic [HOLD_W-1:0] o_hold_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_WIN      = 3'b001,
    S_LOAD     = 3'b010,
    S_EVOLVE   = 3'b011,
    S_WRITEOUT = 3'b100,
    S_HOLD     = 3'b101,
    S_LOSE     = 3'b110,
    S_RESTART  = 3'b111
  } state_t;

  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(CELLS - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GEN_W-1:0]  GEN_MAX   = GEN_W'(GEN_LIMIT);

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_cell_idx;
  logic [GEN_W-1:0]    r_gen_count;
  logic [HOLD_W-1:0]   r_hold_count;
  logic                r_pass_load;   // 1: the pass feeding WRITEOUT was a LOAD
  logic [GEN_W-1:0]    w_gen_inc;     // saturating gen_count + 1
  logic                w_pass_next;   // next state is LOAD or EVOLVE

  logic r_load_en, r_read_en, r_write_en, r_writeout;
  logic r_restart, r_win, r_lose, r_busy;

  assign w_gen_inc   = (r_gen_count >= GEN_MAX) ? r_gen_count : r_gen_count + 1'b1;
  assign w_pass_next = (w_state_next == S_LOAD) || (w_state_next == S_EVOLVE);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clka) begin
    if (reset) r_state <= S_RESTART;
    else       r_state <= w_state_next;
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps every path assigned, so no
  // latch is inferred from the case branches that hold state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RESTART: w_state_next = S_IDLE;
      S_IDLE: begin
        if (i_lose_sig)                            w_state_next = S_LOSE;
        else if (i_load_req)                       w_state_next = S_LOAD;
        else if ((i_run || i_step_req) && !i_pause) w_state_next = S_EVOLVE;
      end
      // Passes are atomic: only the index decides the exit.
      S_LOAD, S_EVOLVE: begin
        if (r_cell_idx == LAST_IDX) w_state_next = S_WRITEOUT;
      end
      S_WRITEOUT: begin
        if (r_pass_load)                w_state_next = S_IDLE;
        else if (w_gen_inc >= GEN_MAX)  w_state_next = S_WIN;   // win beats lose
        else if (i_lose_sig)            w_state_next = S_LOSE;
        else if (i_run && !i_pause)     w_state_next = S_HOLD;
        else                            w_state_next = S_IDLE;
      end
      S_HOLD: begin
        if (i_lose_sig)                    w_state_next = S_LOSE;
        else if (!i_run || i_pause)        w_state_next = S_IDLE;
        else if (r_hold_count == LAST_HOLD) w_state_next = S_EVOLVE;
      end
      S_WIN, S_LOSE: w_state_next = r_state;
      default:       w_state_next = S_RESTART;
    endcase
  end

  // Counters. An index advances only while the FSM stays in the same pass or
  // hold state; any entry into LOAD/EVOLVE/HOLD therefore starts from zero.
  always_ff @(posedge clka) begin
    if (reset) begin
      r_cell_idx   <= '0;
      r_hold_count <= '0;
      r_gen_count  <= '0;
      r_pass_load  <= 1'b0;
    end else begin
      r_cell_idx   <= (w_pass_next && (w_state_next == r_state)) ? r_cell_idx + 1'b1 : '0;
      r_hold_count <= ((w_state_next == S_HOLD) && (r_state == S_HOLD)) ?
                      r_hold_count + 1'b1 : '0;
      if (r_state == S_WRITEOUT)
        r_gen_count <= r_pass_load ? '0 : w_gen_inc;
      if (w_state_next == S_LOAD)        r_pass_load <= 1'b1;
      else if (w_state_next == S_EVOLVE) r_pass_load <= 1'b0;
    end
  end

  // Registered Moore strobes, decoded from the state being entered so they
  // line up with o_state in the same cycle.
  always_ff @(posedge clka) begin
    if (reset) begin
      r_load_en  <= 1'b0;
      r_read_en  <= 1'b0;
      r_write_en <= 1'b0;
      r_writeout <= 1'b0;
      r_restart  <= 1'b1;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_load_en  <= (w_state_next == S_LOAD);
      r_read_en  <= (w_state_next == S_EVOLVE);
      r_write_en <= w_pass_next;
      r_writeout <= (w_state_next == S_WRITEOUT);
      r_restart  <= (w_state_next == S_RESTART);
      r_win      <= (w_state_next == S_WIN);
      r_lose     <= (w_state_next == S_LOSE);
      r_busy     <= w_pass_next || (w_state_next == S_WRITEOUT);
    end
  end

  assign o_state      = r_state;
  assign o_load_en    = r_load_en;
  assign o_read_en    = r_read_en;
  assign o_write_en   = r_write_en;
  assign o_writeout   = r_writeout;
  assign o_restart    = r_restart;
  assign o_win        = r_win;
  assign o_lose       = r_lose;
  assign o_busy       = r_busy;
  assign o_cell_idx   = r_cell_idx;
  assign o_gen_count  = r_gen_count;
  assign o_hold_count = r_hold_count;

endmodule
